addsub_accumulator: RTL

ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

---
 rtl/addsub_accumulator_pkg.sv | 16 +
 rtl/addsub_accumulator_if.sv | 33 +++
 rtl/addsub_core.sv | 31 +++
 rtl/addsub_accumulator.sv | 100 ++++++++++
 4 files changed

// File: rtl/addsub_accumulator_pkg.sv
// Shared types and default parameters for the add/subtract accumulator.
// State encoding is fixed so debug dumps decode the same everywhere.
package addsub_accumulator_pkg;

    localparam int N_DEF   = 4;
    localparam int G_DEF   = 4;
    localparam int SAT_DEF = 1;
    localparam int CW_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_accumulator_if.sv
// Beat input and result output bundle of the accumulator.
// master = producer/consumer side, slave = accumulator side.
interface addsub_accumulator_if
    import addsub_accumulator_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int G  = G_DEF,
    parameter int CW = CW_DEF
) ();

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      a;
    logic [N-1:0]      b;
    logic              k;
    logic              last;
    logic              out_valid;
    logic              out_ready;
    logic [N+G-1:0]    acc_out;
    logic              ovf;
    logic [CW-1:0]     beats;

    modport master (
        output in_valid, a, b, k, last, out_ready,
        input  in_ready, out_valid, acc_out, ovf, beats
    );

    modport slave (
        input  in_valid, a, b, k, last, out_ready,
        output in_ready, out_valid, acc_out, ovf, beats
    );

endinterface

// File: rtl/addsub_core.sv
// Ripple full-adder chain computing A + B or A - B exactly in N+1 bits.
// Subtract inverts B and injects k as the carry into bit 0.
module addsub_core
    import addsub_accumulator_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         k,
    output logic [N:0]   S
);

    logic [N:0] x;
    logic [N:0] y;
    logic [N:0] c;

    assign x    = {A[N-1], A};
    assign y    = {B[N-1], B} ^ {(N+1){k}};
    assign c[0] = k;

    // One full-adder cell per bit; the final carry-out is not needed
    // because the sign-extended result cannot exceed N+1 bits.
    for (genvar i = 0; i <= N; i++) begin : g_fa
        assign S[i] = x[i] ^ y[i] ^ c[i];
        if (i < N) begin : g_carry
            assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Frame accumulator of signed add/subtract beats with overflow handling.
// Result is held in HOLD until the consumer takes it.
module addsub_accumulator
    import addsub_accumulator_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int G   = G_DEF,
    parameter int SAT = SAT_DEF,
    parameter int CW  = CW_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    addsub_accumulator_if.slave io
);

    localparam int W = N + G;

    localparam logic [W-1:0] ACC_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] ACC_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] BEAT_MAX = '1;

    state_t        state;
    logic [W-1:0]  acc;
    logic          ovf_q;
    logic [CW-1:0] beats_q;

    logic          in_ready;
    logic          accept;
    logic          first;
    logic [N:0]    d;
    logic [W:0]    d_ext;
    logic [W:0]    base;
    logic [W:0]    sum;
    logic          sum_ovf;
    logic [W-1:0]  acc_nxt;
    logic [CW-1:0] beats_nxt;

    addsub_core #(
        .N (N)
    ) u_core (
        .A (io.a),
        .B (io.b),
        .k (io.k),
        .S (d)
    );

    // Accept beats unless a result is waiting on a stalled consumer.
    assign in_ready = rst_n & ((state != HOLD) | io.out_ready);
    assign accept   = io.in_valid & in_ready;

    // Any beat taken outside an open frame starts a new one.
    assign first    = (state != ACCUM);

    assign d_ext    = {{(W-N){d[N]}}, d};
    assign base     = first ? '0 : {acc[W-1], acc};
    assign sum      = base + d_ext;
    assign sum_ovf  = sum[W] ^ sum[W-1];

    // Next accumulator value: clamp or wrap when the sum leaves W bits.
    always_comb begin
        acc_nxt = sum[W-1:0];
        if (sum_ovf && (SAT != 0)) begin
            acc_nxt = sum[W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Beat counter restarts at one per frame and sticks at its ceiling.
    always_comb begin
        beats_nxt = beats_q;
        if (first) begin
            beats_nxt = {{(CW-1){1'b0}}, 1'b1};
        end else if (beats_q != BEAT_MAX) begin
            beats_nxt = beats_q + 1'b1;
        end
    end

    // Frame FSM plus accumulator, sticky overflow and beat count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            ovf_q   <= 1'b0;
            beats_q <= '0;
        end else if (accept) begin
            acc     <= acc_nxt;
            ovf_q   <= sum_ovf | (ovf_q & ~first);
            beats_q <= beats_nxt;
            state   <= io.last ? HOLD : ACCUM;
        end else if ((state == HOLD) && io.out_ready) begin
            state   <= IDLE;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = (state == HOLD);
    assign io.acc_out   = acc;
    assign io.ovf       = ovf_q;
    assign io.beats     = beats_q;

endmodule
